// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg-timer controller: state codes, BCD limits,
// button-priority selection and the BCD digit increment helpers.
package egg_timer_pkg;

   localparam int STATE_W = 3;

   // State codes are also exported on the state port for the display mux
   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_SET   = 3'd1;
   localparam logic [STATE_W-1:0] ST_LOAD  = 3'd2;
   localparam logic [STATE_W-1:0] ST_RUN   = 3'd3;
   localparam logic [STATE_W-1:0] ST_PAUSE = 3'd4;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

   localparam logic [3:0] BCD_MAX_ONES     = 4'd9;
   localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

   // The single button that acts in a cycle
   typedef enum logic [2:0] {
      BTN_NONE,
      BTN_STOP,
      BTN_START,
      BTN_SET,
      BTN_MIN,
      BTN_SEC
   } btn_sel_e;

   // Fixed priority stop > start > set > min > sec
   function automatic btn_sel_e btn_priority(input logic stop, input logic start,
                                             input logic set, input logic min,
                                             input logic sec);
      if (stop)       return BTN_STOP;
      else if (start) return BTN_START;
      else if (set)   return BTN_SET;
      else if (min)   return BTN_MIN;
      else if (sec)   return BTN_SEC;
      else            return BTN_NONE;
   endfunction

   // Next value of one BCD digit, wrapping to 0 past max
   function automatic logic [3:0] bcd_next(input logic [3:0] digit, input logic [3:0] max);
      return (digit >= max) ? 4'd0 : digit + 4'd1;
   endfunction

   // {carry, digit}: carry is set when the digit wraps
   function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic [3:0] max);
      return {(digit >= max), bcd_next(digit, max)};
   endfunction

endpackage

// File: rtl/egg_timer_ctrl_if.sv
// Button / countdown-control bundle between the debouncers, the controller
// and the countdown datapath.
interface egg_timer_ctrl_if;
   import egg_timer_pkg::*;

   logic               btn_set;
   logic               btn_min;
   logic               btn_sec;
   logic               btn_start;
   logic               btn_stop;
   logic               time_zero;
   logic               tick_1hz;
   logic               load;
   logic               enable;
   logic               enable_timer;
   logic [3:0]         preset_min_tens;
   logic [3:0]         preset_min_ones;
   logic [3:0]         preset_sec_tens;
   logic [3:0]         preset_sec_ones;
   logic               alarm;
   logic [STATE_W-1:0] state;

   // Controller side
   modport slave (
      input  btn_set, btn_min, btn_sec, btn_start, btn_stop, time_zero,
      output tick_1hz, load, enable, enable_timer,
             preset_min_tens, preset_min_ones, preset_sec_tens, preset_sec_ones,
             alarm, state
   );

   // Environment side (buttons and countdown datapath)
   modport master (
      output btn_set, btn_min, btn_sec, btn_start, btn_stop, time_zero,
      input  tick_1hz, load, enable, enable_timer,
             preset_min_tens, preset_min_ones, preset_sec_tens, preset_sec_ones,
             alarm, state
   );

endinterface

// File: rtl/egg_timer_ctrl_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe every CLK_HZ cycles.
module tick_gen #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick_1hz
);

   localparam int               CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_HZ - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_1hz = (cnt_q == LAST);

   // Wrap at CLK_HZ-1, otherwise count up
   always_comb begin
      cnt_d = tick_1hz ? '0 : cnt_q + ONE;
   end

   // Prescaler register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg-timer sequencing FSM: holds and edits the BCD preset, drives the
// countdown load/enable controls from the 1 Hz tick and times the alarm.
module egg_timer_ctrl
   import egg_timer_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int ALARM_SEC = 10,
   parameter int DEF_MIN   = 3,
   parameter int DEF_SEC   = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   egg_timer_ctrl_if.slave   bus
);

   localparam logic [3:0] DEF_MT = 4'(DEF_MIN / 10);
   localparam logic [3:0] DEF_MO = 4'(DEF_MIN % 10);
   localparam logic [3:0] DEF_ST = 4'(DEF_SEC / 10);
   localparam logic [3:0] DEF_SO = 4'(DEF_SEC % 10);

   localparam int                ACNT_W     = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;
   localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_SEC - 1);
   localparam logic [ACNT_W-1:0] ACNT_ONE   = ACNT_W'(1);

   logic               tick;
   btn_sel_e           sel;
   logic               preset_zero;
   logic [4:0]         ones_inc;

   logic [STATE_W-1:0] state_q, state_d;
   logic [3:0]         min_tens_q, min_tens_d;
   logic [3:0]         min_ones_q, min_ones_d;
   logic [3:0]         sec_tens_q, sec_tens_d;
   logic [3:0]         sec_ones_q, sec_ones_d;
   logic [ACNT_W-1:0]  alarm_cnt_q, alarm_cnt_d;

   tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick_1hz (tick)
   );

   assign sel = btn_priority(bus.btn_stop, bus.btn_start, bus.btn_set,
                             bus.btn_min, bus.btn_sec);
   assign preset_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                        (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

   // Next state, preset edits (SET only) and alarm-second counting (DONE only)
   always_comb begin
      state_d     = state_q;
      min_tens_d  = min_tens_q;
      min_ones_d  = min_ones_q;
      sec_tens_d  = sec_tens_q;
      sec_ones_d  = sec_ones_q;
      alarm_cnt_d = '0;
      ones_inc    = 5'd0;
      case (state_q)
         ST_IDLE: begin
            if (sel == BTN_SET) state_d = ST_SET;
         end
         ST_SET: begin
            case (sel)
               BTN_STOP, BTN_SET: state_d = ST_IDLE;
               BTN_START: begin
                  // A zero preset would alarm immediately, so start is ignored
                  if (!preset_zero) state_d = ST_LOAD;
               end
               BTN_MIN: begin
                  ones_inc   = bcd_inc(min_ones_q, BCD_MAX_ONES);
                  min_ones_d = ones_inc[3:0];
                  if (ones_inc[4]) min_tens_d = bcd_next(min_tens_q, BCD_MAX_ONES);
               end
               BTN_SEC: begin
                  // Seconds wrap 59 -> 00 without touching the minutes
                  ones_inc   = bcd_inc(sec_ones_q, BCD_MAX_ONES);
                  sec_ones_d = ones_inc[3:0];
                  if (ones_inc[4]) sec_tens_d = bcd_next(sec_tens_q, BCD_MAX_SEC_TENS);
               end
               default: ;
            endcase
         end
         ST_LOAD: begin
            // Load stays up through the tick edge the countdown samples it on
            if (sel == BTN_STOP) state_d = ST_IDLE;
            else if (tick)       state_d = ST_RUN;
         end
         ST_RUN: begin
            // time_zero is ignored on tick cycles while the digits are changing
            if (sel == BTN_STOP)             state_d = ST_PAUSE;
            else if (bus.time_zero && !tick) state_d = ST_DONE;
         end
         ST_PAUSE: begin
            case (sel)
               BTN_START: state_d = ST_RUN;
               BTN_STOP:  state_d = ST_IDLE;
               BTN_SET:   state_d = ST_SET;
               default: ;
            endcase
         end
         ST_DONE: begin
            if (sel != BTN_NONE) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (alarm_cnt_q == ALARM_LAST) state_d = ST_IDLE;
               else                           alarm_cnt_d = alarm_cnt_q + ACNT_ONE;
            end else begin
               alarm_cnt_d = alarm_cnt_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, preset and alarm counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         min_tens_q  <= DEF_MT;
         min_ones_q  <= DEF_MO;
         sec_tens_q  <= DEF_ST;
         sec_ones_q  <= DEF_SO;
         alarm_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         min_tens_q  <= min_tens_d;
         min_ones_q  <= min_ones_d;
         sec_tens_q  <= sec_tens_d;
         sec_ones_q  <= sec_ones_d;
         alarm_cnt_q <= alarm_cnt_d;
      end
   end

   // Moore outputs decoded from the state register
   assign bus.tick_1hz        = tick;
   assign bus.load            = (state_q == ST_LOAD);
   assign bus.enable          = (state_q == ST_RUN);
   assign bus.enable_timer    = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                                (state_q == ST_PAUSE) || (state_q == ST_DONE);
   assign bus.alarm           = (state_q == ST_DONE);
   assign bus.state           = state_q;
   assign bus.preset_min_tens = min_tens_q;
   assign bus.preset_min_ones = min_ones_q;
   assign bus.preset_sec_tens = sec_tens_q;
   assign bus.preset_sec_ones = sec_ones_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: a behavioural model (integer minutes/seconds,
// cycle counter) checked against the DUT every cycle, directed scenarios with
// literal expectations, then randomized button/time_zero stimulus.
module tb_egg_timer_ctrl;

   localparam int CLK_HZ    = 10;
   localparam int ALARM_SEC = 3;

   localparam logic [4:0] B_NONE  = 5'b00000;
   localparam logic [4:0] B_STOP  = 5'b10000;
   localparam logic [4:0] B_START = 5'b01000;
   localparam logic [4:0] B_SET   = 5'b00100;
   localparam logic [4:0] B_MIN   = 5'b00010;
   localparam logic [4:0] B_SEC   = 5'b00001;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] btns = 5'b0;    // {stop,start,set,min,sec}
   logic       tz_rand_en = 1'b0;
   logic       tz_rand = 1'b0;
   logic       cmp_en = 1'b0;
   int         env_cnt;
   int         n_checks = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   egg_timer_ctrl_if bus();

   egg_timer_ctrl #(
      .CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC), .DEF_MIN(3), .DEF_SEC(0)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign bus.btn_stop  = btns[4];
   assign bus.btn_start = btns[3];
   assign bus.btn_set   = btns[2];
   assign bus.btn_min   = btns[1];
   assign bus.btn_sec   = btns[0];
   assign bus.time_zero = tz_rand_en ? tz_rand : (env_cnt == 0);

   // Countdown datapath stand-in (stimulus only): seconds remaining, loaded,
   // decremented or cleared on each tick as the controls request
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) env_cnt <= 0;
      else if (bus.tick_1hz) begin
         if (!bus.enable_timer) env_cnt <= 0;
         else if (bus.load)
            env_cnt <= (bus.preset_min_tens * 10 + bus.preset_min_ones) * 60 +
                       bus.preset_sec_tens * 10 + bus.preset_sec_ones;
         else if (bus.enable && env_cnt > 0) env_cnt <= env_cnt - 1;
      end
   end

   // ---------------- behavioural model ----------------
   typedef struct {
      int st;    // 0 IDLE 1 SET 2 LOAD 3 RUN 4 PAUSE 5 DONE
      int pm;    // preset minutes 0..99
      int ps;    // preset seconds 0..59
      int secs;  // alarm seconds elapsed
   } mstate_t;

   mstate_t m;
   int      m_cyc;  // cycles since reset release, modulo CLK_HZ

   function automatic mstate_t model_next(input mstate_t s, input bit tick,
                                          input logic [4:0] b, input bit tz);
      mstate_t n = s;
      logic [4:0] act = 5'b0;
      // only the highest-priority pulse counts
      for (int k = 4; k >= 0; k--) if (b[k] && act == 5'b0) act[k] = 1'b1;
      n.secs = 0;
      case (s.st)
         0: if (act == B_SET) n.st = 1;
         1: begin
            if (act == B_STOP || act == B_SET) n.st = 0;
            else if (act == B_START && (s.pm * 60 + s.ps) > 0) n.st = 2;
            else if (act == B_MIN) n.pm = (s.pm + 1) % 100;
            else if (act == B_SEC) n.ps = (s.ps + 1) % 60;
         end
         2: if (act == B_STOP) n.st = 0; else if (tick) n.st = 3;
         3: if (act == B_STOP) n.st = 4; else if (tz && !tick) n.st = 5;
         4: if (act == B_START) n.st = 3; else if (act == B_STOP) n.st = 0;
            else if (act == B_SET) n.st = 1;
         5: begin
            if (act != 5'b0) n.st = 0;
            else if (tick) begin
               if (s.secs + 1 >= ALARM_SEC) n.st = 0;
               else n.secs = s.secs + 1;
            end else n.secs = s.secs;
         end
         default: n.st = 0;
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m     <= '{0, 3, 0, 0};
         m_cyc <= 0;
      end else begin
         m     <= model_next(m, (m_cyc == CLK_HZ - 1), btns, bus.time_zero);
         m_cyc <= (m_cyc + 1) % CLK_HZ;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [15:0] dut_preset();
      return {bus.preset_min_tens, bus.preset_min_ones, bus.preset_sec_tens, bus.preset_sec_ones};
   endfunction

   function automatic logic [4:0] dut_ctrl();
      return {bus.tick_1hz, bus.load, bus.enable, bus.enable_timer, bus.alarm};
   endfunction

   // Every-cycle compare: {state, tick, load, enable, enable_timer, alarm, preset}
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [23:0] exp_v;
         logic [2:0]  st3;
         st3   = 3'(m.st);
         exp_v = {st3, (m_cyc == CLK_HZ - 1), (m.st == 2), (m.st == 3),
                  (m.st >= 2 && m.st <= 5), (m.st == 5),
                  4'(m.pm / 10), 4'(m.pm % 10), 4'(m.ps / 10), 4'(m.ps % 10)};
         check("cycle {state,tick,load,en,en_tmr,alarm,preset}",
               {8'h0, bus.state, dut_ctrl(), dut_preset()}, {8'h0, exp_v});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic [4:0] b, input string what);
      btns = b;
      if (what != "") $display("txn t=%0t %s buttons=%05b", $time, what, b);
      @(negedge clk);
      btns = B_NONE;
   endtask

   task automatic idle(input int n);
      repeat (n) step(B_NONE, "");
   endtask

   task automatic wait_state(input logic [2:0] code, input int budget, input string name);
      int k = 0;
      while (bus.state !== code && k < budget) begin
         step(B_NONE, "");
         k++;
      end
      if (bus.state !== code) check({name, " timeout"}, 32'(bus.state), 32'(code));
   endtask

   task automatic wait_tick_seen(input int budget);
      int k = 0;
      while (bus.tick_1hz !== 1'b1 && k < budget) begin
         step(B_NONE, "");
         k++;
      end
      if (bus.tick_1hz !== 1'b1) check("tick wait timeout", 32'(bus.tick_1hz), 32'd1);
   endtask

   task automatic reset_now_and_check(input string name);
      #2 reset_n = 1'b0;
      #1;
      check({name, " state"},    32'(bus.state), 32'd0);
      check({name, " controls"}, 32'(dut_ctrl()), 32'd0);
      check({name, " preset"},   32'(dut_preset()), 32'h0300);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      int ticks;
      int k;
      logic [4:0] b;

      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("reset state",    32'(bus.state), 32'd0);
      check("reset preset",   32'(dut_preset()), 32'h0300);
      check("reset controls", 32'(dut_ctrl()), 32'd0);
      reset_n = 1'b1;
      $display("txn t=%0t reset released", $time);

      // prescaler: high on the 10th cycle after release, then every 10
      idle(8);  check("tick before first period", 32'(bus.tick_1hz), 32'd0);
      idle(1);  check("first tick",               32'(bus.tick_1hz), 32'd1);
      idle(1);  check("tick one cycle wide",      32'(bus.tick_1hz), 32'd0);
      idle(9);  check("second tick",              32'(bus.tick_1hz), 32'd1);

      // preset editing
      step(B_SET, "set");
      check("enter SET", 32'(bus.state), 32'd1);
      for (int i = 0; i < 60; i++) step(B_SEC, "");
      $display("txn t=%0t 60x btn_sec", $time);
      check("60x sec wraps", 32'(dut_preset()), 32'h0300);
      for (int i = 0; i < 99; i++) step(B_MIN, "");
      $display("txn t=%0t 99x btn_min", $time);
      check("99x min from 03", 32'(dut_preset()), 32'h0200);
      for (int i = 0; i < 98; i++) step(B_MIN, "");
      $display("txn t=%0t 98x btn_min", $time);
      check("min to 00", 32'(dut_preset()), 32'h0000);
      step(B_START, "start with 00:00");
      check("zero preset start ignored", 32'(bus.state), 32'd1);
      step(B_SEC, "sec"); step(B_SEC, "sec");
      check("preset 00:02", 32'(dut_preset()), 32'h0002);

      // start mid-period, load held until the tick, then run 2 s to DONE
      if (bus.tick_1hz) step(B_NONE, "");
      step(B_START, "start");
      check("LOAD state", 32'(bus.state), 32'd2);
      check("load high",  32'(bus.load), 32'd1);
      wait_tick_seen(15);
      step(B_NONE, "");
      check("RUN after tick", 32'(bus.state), 32'd3);
      check("enable in RUN",  32'({bus.load, bus.enable}), 32'b01);
      ticks = 0; k = 0;
      while (bus.state === 3'd3 && k < 60) begin
         if (bus.tick_1hz) ticks++;
         step(B_NONE, ""); k++;
      end
      check("DONE reached",  32'(bus.state), 32'd5);
      check("alarm on",      32'(bus.alarm), 32'd1);
      check("ticks in RUN",  32'(ticks), 32'd2);

      // alarm auto-returns after ALARM_SEC ticks
      ticks = 0; k = 0;
      while (bus.state === 3'd5 && k < 60) begin
         if (bus.tick_1hz) ticks++;
         step(B_NONE, ""); k++;
      end
      check("alarm ticks", 32'(ticks), 32'd3);
      check("alarm off",   32'({bus.alarm, bus.state}), 32'd0);

      // button in DONE returns to IDLE next cycle
      step(B_SET, "set"); step(B_START, "start");
      wait_state(3'd5, 80, "reach DONE again");
      step(B_SET, "set in DONE");
      check("DONE + btn_set", 32'({bus.alarm, bus.state}), 32'd0);

      // pause / resume / abort
      step(B_SET, "set"); step(B_START, "start");
      wait_state(3'd3, 30, "reach RUN");
      step(B_STOP, "stop");
      check("PAUSE", 32'({bus.state, bus.enable, bus.enable_timer}), {27'd0, 3'd4, 1'b0, 1'b1});
      step(B_START, "resume");
      check("resume RUN", 32'({bus.state, bus.enable}), {28'd0, 3'd3, 1'b1});
      step(B_STOP, "stop");
      step(B_STOP, "stop");
      check("abort IDLE", 32'({bus.state, bus.enable_timer}), 32'd0);

      // stop beats start
      step(B_SET, "set"); step(B_START, "start");
      wait_state(3'd3, 30, "reach RUN");
      step(B_STOP | B_START, "stop+start");
      check("stop priority", 32'(bus.state), 32'd4);
      step(B_STOP, "stop");

      // asynchronous reset in LOAD and in RUN
      step(B_SET, "set"); step(B_START, "start");
      check("LOAD before reset", 32'(bus.state), 32'd2);
      reset_now_and_check("reset in LOAD");
      step(B_SET, "set"); step(B_START, "start");
      wait_state(3'd3, 30, "reach RUN");
      reset_now_and_check("reset in RUN");

      // randomized phase
      $display("txn t=%0t random phase start", $time);
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) tz_rand_en = 1'($urandom_range(0, 1));
         tz_rand = ($urandom_range(0, 7) == 0);
         b = B_NONE;
         for (int j = 0; j < 5; j++) b[j] = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 19) == 0) b[2] = 1'b1;
         step(b, "");
      end
      tz_rand_en = 1'b0;
      $display("txn t=%0t random phase end", $time);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
